// File: rtl/sgm_frame_sequencer.sv
// SGM frame sequencer: pixel coordinates, path-beginning strobes, frame-atomic P1/P2 commit; outputs 1 cycle after de_in.
// cfg_ready drops only for the commit cycle. Define SGM_FRAME_STATS_EN for frame/error counters and the h_sync check.
module sgm_frame_sequencer #(
  parameter int         HALF_IMG_WIDTH = 640,
  parameter int         IMG_HEIGHT     = 720,
  parameter int         ROW_WIDTH      = 10,
  parameter int         COL_WIDTH      = 11,
  parameter logic [7:0] P1_RESET       = 8'd15,
  parameter logic [7:0] P2_RESET       = 8'd64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 de_in,
  input  logic                 h_sync_in,
  input  logic                 v_sync_in,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic                 cfg_addr,
  input  logic [7:0]           cfg_wdata,
  output logic [7:0]           p1_out,
  output logic [7:0]           p2_out,
  output logic [ROW_WIDTH-1:0] row_out,
  output logic [COL_WIDTH-1:0] col_out,
  output logic                 de_out,
  output logic                 half_img_de,
  output logic                 extended_de,
  output logic                 horizontal_beginning,
  output logic                 top_to_bottom_beginning,
  output logic                 diag_l2r_beginning,
  output logic                 diag_r2l_beginning,
  output logic                 frame_error
`ifdef SGM_FRAME_STATS_EN
  ,
  output logic [15:0]          frame_count,
  output logic [7:0]           error_count
`endif
);

  localparam logic [COL_WIDTH-1:0] C_HALF   = COL_WIDTH'(HALF_IMG_WIDTH);
  localparam logic [COL_WIDTH-1:0] C_LAST   = COL_WIDTH'(2 * HALF_IMG_WIDTH - 1);
  localparam logic [ROW_WIDTH-1:0] C_HEIGHT = ROW_WIDTH'(IMG_HEIGHT);

  typedef enum logic [1:0] {S_SYNC, S_COMMIT, S_FRAME} state_t;

  state_t     r_state;
  logic       r_de_d;
  logic       r_vs_d;
  logic       r_err_pend;
  logic [7:0] r_sh_p1;
  logic [7:0] r_sh_p2;

  logic                 w_vs_rise, w_de_rise, w_de_fall, w_in_frame, w_de_acc;
  logic [COL_WIDTH-1:0] w_col_nxt;
  logic [ROW_WIDTH-1:0] w_row_nxt;
  logic                 w_half_nxt, w_hb_nxt, w_ttb_nxt, w_r2l_nxt;
  logic                 w_len_err, w_row_err, w_hs_err;
  logic [7:0]           w_p2_commit;

  assign w_vs_rise  = v_sync_in & ~r_vs_d;
  assign w_de_rise  = de_in & ~r_de_d;
  assign w_de_fall  = ~de_in & r_de_d;
  assign w_in_frame = (r_state == S_FRAME);
  // A pixel coinciding with the v_sync rising edge is dropped
  assign w_de_acc   = de_in & w_in_frame & ~w_vs_rise;

  always_comb begin
    w_col_nxt = col_out;
    if (w_de_acc) w_col_nxt = w_de_rise ? '0 : col_out + 1'b1;
    w_row_nxt = row_out;
    if (w_vs_rise) w_row_nxt = '0;
    else if (w_in_frame && w_de_fall && row_out != '1) w_row_nxt = row_out + 1'b1;
  end

  assign w_half_nxt  = w_de_acc && (w_col_nxt >= C_HALF);
  assign w_hb_nxt    = w_de_acc && (w_col_nxt == C_HALF);
  assign w_ttb_nxt   = w_de_acc && (w_row_nxt == '0);
  assign w_r2l_nxt   = w_de_acc && (w_col_nxt == C_LAST);
  // de_out still marks the last accepted pixel, so col_out is its index
  assign w_len_err   = w_in_frame && w_de_fall && de_out && (col_out != C_LAST);
  assign w_row_err   = w_in_frame && w_de_rise && (row_out >= C_HEIGHT);
  assign w_p2_commit = (r_sh_p2 > r_sh_p1) ? r_sh_p2 : r_sh_p1;

`ifdef SGM_FRAME_STATS_EN
  assign w_hs_err = w_in_frame && h_sync_in && de_in;
`else
  logic w_unused_hsync;
  assign w_unused_hsync = h_sync_in;
  assign w_hs_err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state                 <= S_SYNC;
      r_de_d                  <= 1'b0;
      r_vs_d                  <= 1'b0;
      r_err_pend              <= 1'b0;
      r_sh_p1                 <= P1_RESET;
      r_sh_p2                 <= P2_RESET;
      cfg_ready               <= 1'b1;
      p1_out                  <= P1_RESET;
      p2_out                  <= P2_RESET;
      row_out                 <= '0;
      col_out                 <= '0;
      de_out                  <= 1'b0;
      half_img_de             <= 1'b0;
      extended_de             <= 1'b0;
      horizontal_beginning    <= 1'b0;
      top_to_bottom_beginning <= 1'b0;
      diag_l2r_beginning      <= 1'b0;
      diag_r2l_beginning      <= 1'b0;
      frame_error             <= 1'b0;
`ifdef SGM_FRAME_STATS_EN
      frame_count             <= '0;
      error_count             <= '0;
`endif
    end else begin
      r_de_d <= de_in;
      r_vs_d <= v_sync_in;
      if (cfg_valid && cfg_ready) begin
        if (cfg_addr) r_sh_p2 <= cfg_wdata;
        else          r_sh_p1 <= cfg_wdata;
      end
      if (w_vs_rise && de_in) r_err_pend <= 1'b1;

      row_out                 <= w_row_nxt;
      col_out                 <= w_col_nxt;
      de_out                  <= w_de_acc;
      half_img_de             <= w_half_nxt;
      extended_de             <= w_half_nxt | half_img_de;
      horizontal_beginning    <= w_hb_nxt;
      top_to_bottom_beginning <= w_ttb_nxt;
      diag_l2r_beginning      <= w_hb_nxt | w_ttb_nxt;
      diag_r2l_beginning      <= w_r2l_nxt | w_ttb_nxt;

      case (r_state)
        S_SYNC: begin
          if (w_vs_rise) begin
            r_state   <= S_COMMIT;
            cfg_ready <= 1'b0;
          end
        end
        S_COMMIT: begin
          p1_out      <= r_sh_p1;
          p2_out      <= w_p2_commit;
          frame_error <= r_err_pend;
          r_err_pend  <= 1'b0;
          cfg_ready   <= 1'b1;
          r_state     <= S_FRAME;
`ifdef SGM_FRAME_STATS_EN
          frame_count <= frame_count + 16'd1;
          if (frame_error && error_count != 8'hFF) error_count <= error_count + 8'd1;
`endif
        end
        S_FRAME: begin
          if (w_len_err || w_row_err || w_hs_err) frame_error <= 1'b1;
          if (w_vs_rise) begin
            r_state   <= S_COMMIT;
            cfg_ready <= 1'b0;
          end
        end
        default: r_state <= S_SYNC;
      endcase
    end
  end

endmodule

// File: doc/sgm_frame_sequencer.md
Name: sgm_frame_sequencer

Overview:
Frame-level sequencer for the SGM disparity pipeline. Tracks video timing and produces the per-pixel row/column coordinates, the path-beginning strobes for the four path cost calculators (horizontal, top-to-bottom, diagonal L→R, diagonal R→L), and the half-image and extended data-enable signals. Holds the run-time P1/P2 penalty configuration in shadow registers and commits it atomically at each frame boundary, so penalties never change mid-frame. Sits between the cost-stage timing outputs and the path cost calculators.

Parameters:
HALF_IMG_WIDTH, 640, columns in left half; full active line is 2*HALF_IMG_WIDTH.
IMG_HEIGHT, 720, expected active lines per frame.
ROW_WIDTH, 10, row counter width.
COL_WIDTH, 11, column counter width.
P1_RESET, 15, P1 value after reset (8-bit).
P2_RESET, 64, P2 value after reset (8-bit).

Ports:
clk  in  1  pixel clock; single clock domain
rst  in  1  synchronous, active-high reset
de_in  in  1  data enable from cost stage
h_sync_in  in  1  horizontal sync, active-high
v_sync_in  in  1  vertical sync, active-high
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accepted when high together with cfg_valid
cfg_addr  in  1  0 = P1, 1 = P2
cfg_wdata  in  8  config value
p1_out  out  8  committed P1
p2_out  out  8  committed P2
row_out  out  ROW_WIDTH  row of the pixel currently on de_out
col_out  out  COL_WIDTH  column of the pixel currently on de_out
de_out  out  1  de_in delayed by 1 cycle
half_img_de  out  1  de_out && col_out >= HALF_IMG_WIDTH
extended_de  out  1  half_img_de OR half_img_de of previous cycle
horizontal_beginning  out  1  col_out == HALF_IMG_WIDTH
top_to_bottom_beginning  out  1  row_out == 0
diag_l2r_beginning  out  1  horizontal_beginning || top_to_bottom_beginning
diag_r2l_beginning  out  1  (col_out == 2*HALF_IMG_WIDTH-1) || top_to_bottom_beginning
frame_error  out  1  timing violation detected in the current frame

Behaviour:
- Reset (synchronous, active-high):
  - All outputs 0, except p1_out=P1_RESET, p2_out=P2_RESET, cfg_ready=1.
  - Shadows load P1_RESET/P2_RESET.
  - FSM enters S_SYNC.
- Latency: every timing output is registered, 1 cycle after the de_in sample it describes.
- Beginning strobes are gated by de_out; they are 0 whenever de_out=0.
- Column counter:
  - Pixel k of a line (0-based) appears with col_out=k.
  - Counter clears on the de_in rising edge.
- Row counter:
  - Increments on each de_in falling edge.
  - Clears on the v_sync_in rising edge.
  - Saturates at 2^ROW_WIDTH-1.
- FSM:
  - S_SYNC: de_in is ignored; de_out and all strobes stay 0. On v_sync_in rising edge → S_COMMIT.
  - S_COMMIT (exactly 1 cycle):
    - cfg_ready=0.
    - p1_out ← shadow_p1.
    - p2_out ← max(shadow_p1, shadow_p2). Clamp so that P2 ≥ P1.
    - frame_error ← 0.
    - Next state: S_FRAME.
  - S_FRAME: counting is active. On v_sync_in rising edge → S_COMMIT.
- Config handshake:
  - A write occurs when cfg_valid && cfg_ready; it updates the shadow selected by cfg_addr.
  - Writes never alter p1_out/p2_out before the next S_COMMIT.
  - The last write before commit wins.
  - During S_COMMIT the requester holds cfg_valid and its data; the write lands the next cycle and takes effect one frame later.
- frame_error (sticky until the next S_COMMIT) is set when either:
  - a de_in falling edge ends a line whose length ≠ 2*HALF_IMG_WIDTH, or
  - de_in rises while row count ≥ IMG_HEIGHT.
- Simultaneous events:
  - v_sync_in rising edge in the same cycle as de_in=1: the pixel is dropped (de_out=0) and a frame error is flagged for the next frame. This is done by setting a pending bit that is applied after the commit.
  - rst has priority over everything.
- h_sync_in is only delayed (not used for counting). It exists for alignment checks in the optional feature.

Optional Feature:
Macro SGM_FRAME_STATS_EN.
- Defined:
  - Adds output frame_count[15:0]: increments at every S_COMMIT and wraps from 0xFFFF to 0.
  - Adds output error_count[7:0]: increments, saturating at 0xFF, for each frame that ends with frame_error=1.
  - Both reset to 0.
  - Additionally, h_sync_in high while de_in=1 sets frame_error.
- Undefined: neither port exists and the h_sync check is absent; all other behaviour is identical.

Test Plan:
- Reset, then 2 frames of 4 lines × 1280 pixels (HALF_IMG_WIDTH=640, IMG_HEIGHT=4):
  - horizontal_beginning pulses once per line at col_out=640.
  - diag_r2l_beginning is high at col 1279 and for all of row 0.
  - frame_error=0.
- Write P1=20, P2=10 mid-frame → p1_out/p2_out stay 15/64 until the next v_sync rising edge + 1 cycle, then become 20/20 (clamped).
- Hold cfg_valid during the S_COMMIT cycle → cfg_ready=0 for exactly 1 cycle; the write completes the next cycle and is visible only after the following frame's commit.
- A 1279-pixel line in frame 1 → frame_error=1 from that line end until the frame 2 commit, then 0.
- Assert rst mid-line → next cycle all strobes, row_out and col_out are 0 and p1_out=15, p2_out=64; de_in is ignored until a v_sync rising edge.
- With SGM_FRAME_STATS_EN: after 3 frames, one of them erroneous → frame_count=3, error_count=1.
